// File: rtl/n64_ioctl_pkg.sv
// rtl/n64_ioctl_pkg.sv - shared types and defaults for the hps_io ioctl upload/download helpers
package n64_ioctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } rd_state_e;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  localparam logic [5:0] CART_INDEX_DEFAULT = 6'd1;
  localparam logic [5:0] SAVE_INDEX_DEFAULT = 6'd2;

  // Same lane order as the download packer: even halfword in the low lane.
  function automatic logic [15:0] select_half(input logic [31:0] word, input logic hi);
    return (hi == HALF_HI) ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/ioctl_upload_reader.sv
// rtl/ioctl_upload_reader.sv - serves hps_io upload reads from a one-word SDRAM cache
// Demand misses stall the HPS; serving an upper half prefetches the next word in the background.
module ioctl_upload_reader
  import n64_ioctl_pkg::*;
#(
  parameter logic [26:0] BASE_ADDR    = 27'd0,
  parameter logic [5:0]  UPLOAD_INDEX = SAVE_INDEX_DEFAULT,
  parameter bit          PREFETCH     = 1'b1
) (
  input  logic        clk1x,
  input  logic        reset_n,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [26:0] ioctl_addr,
  output logic [15:0] ioctl_din,
  output logic        ioctl_wait,
  output logic [26:0] sdr_addr,
  output logic        sdr_req,
  output logic        sdr_rnw,
  input  logic [31:0] sdr_dout,
  input  logic        sdr_ready,
  output logic        active
);

  rd_state_e   state_q, state_d;
  logic        active_q, active_d;
  logic        valid_q, valid_d;
  logic [24:0] tag_q, tag_d;
  logic [31:0] word_q, word_d;
  logic [24:0] fetch_tag_q, fetch_tag_d;
  logic        demand_q, demand_d;
  logic        pend_q, pend_d;
  logic [26:1] pend_addr_q, pend_addr_d;
  logic        discard_q, discard_d;
  logic [15:0] din_q, din_d;
  logic        wait_q, wait_d;
  logic        req_q, req_d;
  logic [26:0] sdr_addr_q, sdr_addr_d;

  logic        rd_take;
  logic        eff_pend;
  logic [26:1] eff_addr;
  logic        unused_bits;

  assign unused_bits = ^{ioctl_index[7:6], ioctl_addr[0]};

  // A strobe is only honoured while the session is live on both sides of the edge.
  assign rd_take  = ioctl_rd && active_q && active_d && !wait_q;
  assign eff_pend = pend_q || rd_take;
  assign eff_addr = rd_take ? ioctl_addr[26:1] : pend_addr_q;

  always_comb begin
    active_d    = ioctl_upload && (ioctl_index[5:0] == UPLOAD_INDEX);
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    word_d      = word_q;
    fetch_tag_d = fetch_tag_q;
    demand_d    = demand_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    discard_d   = discard_q;
    din_d       = din_q;
    wait_d      = wait_q;
    req_d       = 1'b0;
    sdr_addr_d  = sdr_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rd_take) begin
          if (valid_q && (tag_q == ioctl_addr[26:2])) begin
            din_d = select_half(word_q, ioctl_addr[1]);
            if (PREFETCH && (ioctl_addr[1] == HALF_HI)) begin
              state_d     = ST_REQ;
              demand_d    = 1'b0;
              fetch_tag_d = tag_q + 25'd1;
            end
          end else begin
            state_d     = ST_REQ;
            demand_d    = 1'b1;
            fetch_tag_d = ioctl_addr[26:2];
            pend_d      = 1'b1;
            pend_addr_d = ioctl_addr[26:1];
            wait_d      = 1'b1;
          end
        end
      end
      ST_REQ: begin
        req_d      = 1'b1;
        sdr_addr_d = BASE_ADDR + {fetch_tag_q, 2'b00};
        state_d    = ST_WAIT;
        if (rd_take) begin
          pend_d      = 1'b1;
          pend_addr_d = ioctl_addr[26:1];
          wait_d      = 1'b1;
        end
      end
      ST_WAIT: begin
        if (rd_take) begin
          pend_d      = 1'b1;
          pend_addr_d = ioctl_addr[26:1];
          wait_d      = 1'b1;
        end
        if (sdr_ready) begin
          discard_d = 1'b0;
          state_d   = ST_IDLE;
          pend_d    = 1'b0;
          if (!discard_q) begin
            tag_d   = fetch_tag_q;
            word_d  = sdr_dout;
            valid_d = 1'b1;
          end
          // The held read is re-judged against the word that just arrived.
          if (eff_pend) begin
            if (!discard_q && (fetch_tag_q == eff_addr[26:2])) begin
              din_d  = select_half(sdr_dout, eff_addr[1]);
              wait_d = 1'b0;
            end else begin
              state_d     = ST_REQ;
              demand_d    = 1'b1;
              fetch_tag_d = eff_addr[26:2];
              pend_d      = 1'b1;
              pend_addr_d = eff_addr;
              wait_d      = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Session end: release the HPS at once; an issued access must still drain.
    if (!active_d) begin
      valid_d = 1'b0;
      pend_d  = 1'b0;
      wait_d  = 1'b0;
      din_d   = din_q;
      if (state_q == ST_REQ) begin
        state_d    = ST_IDLE;
        req_d      = 1'b0;
        sdr_addr_d = sdr_addr_q;
      end else if (state_q == ST_WAIT) begin
        state_d   = sdr_ready ? ST_IDLE : ST_WAIT;
        discard_d = !sdr_ready;
      end
    end else if (!active_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk1x or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      active_q    <= 1'b0;
      valid_q     <= 1'b0;
      tag_q       <= '0;
      word_q      <= '0;
      fetch_tag_q <= '0;
      demand_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      discard_q   <= 1'b0;
      din_q       <= '0;
      wait_q      <= 1'b0;
      req_q       <= 1'b0;
      sdr_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      word_q      <= word_d;
      fetch_tag_q <= fetch_tag_d;
      demand_q    <= demand_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      discard_q   <= discard_d;
      din_q       <= din_d;
      wait_q      <= wait_d;
      req_q       <= req_d;
      sdr_addr_q  <= sdr_addr_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign sdr_addr   = sdr_addr_q;
  assign sdr_req    = req_q;
  assign sdr_rnw    = 1'b1;
  assign active     = active_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// tb/tb_ioctl_upload_reader.sv - self-checking bench for ioctl_upload_reader
// SDRAM is a hashed word store with overrides; reads are judged by address, not by DUT internals.
module tb_ioctl_upload_reader;

  localparam logic [26:0] BASE = 27'h100000;

  logic        clk1x = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd2;
  logic        ioctl_rd = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [31:0] sdr_dout = '0;
  logic        sdr_ready = 1'b0;
  logic [15:0] ioctl_din;
  logic        ioctl_wait;
  logic [26:0] sdr_addr;
  logic        sdr_req;
  logic        sdr_rnw;
  logic        active;

  int total = 0;
  int bad = 0;
  int lat = 2;
  bit rand_lat = 1'b0;
  bit [31:0] mem_over [int];
  logic [26:0] req_log [$];

  typedef struct {
    logic [26:0] addr;
    logic [15:0] din;
    logic        stall;
    int          nreq;
    logic [26:0] req;
  } vec_t;

  ioctl_upload_reader #(.BASE_ADDR(BASE), .UPLOAD_INDEX(6'd2), .PREFETCH(1'b1)) dut (
    .clk1x(clk1x), .reset_n(reset_n), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_rnw(sdr_rnw), .sdr_dout(sdr_dout),
    .sdr_ready(sdr_ready), .active(active)
  );

  initial forever #5 clk1x = ~clk1x;

  function automatic logic [31:0] mem_word(input logic [26:0] a);
    if (mem_over.exists(int'(a))) return mem_over[int'(a)];
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [15:0] exp_half(input logic [26:0] a);
    logic [31:0] w;
    w = mem_word(BASE + {a[26:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1x);
    #1;
  endtask

  task automatic do_rd(input logic [26:0] a, output logic [15:0] d, output logic stalled);
    int n;
    ioctl_addr = a;
    ioctl_rd = 1'b1;
    step();
    ioctl_rd = 1'b0;
    stalled = 1'b0;
    n = 0;
    while (ioctl_wait === 1'b1 && n < 80) begin
      stalled = 1'b1;
      step();
      n++;
    end
    chk("rd_wait_release", 32'(ioctl_wait), 32'h0);
    d = ioctl_din;
  endtask

  // One access at a time, answered a fixed or random number of cycles after the request.
  initial begin
    logic [26:0] a;
    int n;
    forever begin
      @(posedge clk1x);
      #1;
      if (sdr_req === 1'b1 && reset_n) begin
        a = sdr_addr;
        req_log.push_back(a);
        n = rand_lat ? int'($urandom_range(1, 4)) : lat;
        repeat (n) begin
          @(posedge clk1x);
          #1;
        end
        sdr_dout = mem_word(a);
        sdr_ready = 1'b1;
        @(posedge clk1x);
        #1;
        sdr_ready = 1'b0;
        sdr_dout = 32'h0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [10];
    logic [15:0] d, d0;
    logic s;
    logic [26:0] a, cur_w, prev_w, base_w;
    bit ok;

    mem_over[int'(BASE + 27'h0)]   = 32'hA1B2C3D4;
    mem_over[int'(BASE + 27'h4)]   = 32'h11223344;
    mem_over[int'(BASE + 27'h100)] = 32'hDEADBEEF;
    mem_over[int'(27'h0FFFFC)]     = 32'hCAFEF00D;

    tbl[0] = '{27'h0,       16'hC3D4, 1'b1, 1, BASE + 27'h0};
    tbl[1] = '{27'h2,       16'hA1B2, 1'b0, 1, BASE + 27'h4};
    tbl[2] = '{27'h4,       16'h3344, 1'b0, 0, 27'h0};
    tbl[3] = '{27'h6,       16'h1122, 1'b0, 1, BASE + 27'h8};
    tbl[4] = '{27'h100,     16'hBEEF, 1'b1, 1, BASE + 27'h100};
    tbl[5] = '{27'h100,     16'hBEEF, 1'b0, 0, 27'h0};
    tbl[6] = '{27'h102,     16'hDEAD, 1'b0, 1, BASE + 27'h104};
    tbl[7] = '{27'h7FFFFFC, 16'hF00D, 1'b1, 1, 27'h0FFFFC};
    tbl[8] = '{27'h7FFFFFE, 16'hCAFE, 1'b0, 1, BASE};
    tbl[9] = '{27'h0,       16'hC3D4, 1'b0, 0, 27'h0};

    // Held in reset with strobes flying: everything stays quiet.
    ioctl_upload = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ioctl_addr = 27'(i * 2);
      ioctl_rd = i[0];
      step();
    end
    ioctl_rd = 1'b0;
    chk("rst_din", 32'(ioctl_din), 32'h0);
    chk("rst_wait", 32'(ioctl_wait), 32'h0);
    chk("rst_req", 32'(sdr_req), 32'h0);
    chk("rst_addr", 32'(sdr_addr), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_nreq", 32'(req_log.size()), 32'h0);

    reset_n = 1'b1;
    repeat (3) step();
    chk("active_up", 32'(active), 32'h1);
    chk("rnw", 32'(sdr_rnw), 32'h1);

    // Exact miss timing with a two-cycle SDRAM.
    ioctl_addr = 27'h300;
    ioctl_rd = 1'b1;
    step();
    ioctl_rd = 1'b0;
    chk("lat_wait1", 32'(ioctl_wait), 32'h1);
    chk("lat_noreq1", 32'(sdr_req), 32'h0);
    step();
    chk("lat_req2", 32'(sdr_req), 32'h1);
    chk("lat_addr2", 32'(sdr_addr), 32'(BASE + 27'h300));
    step();
    chk("lat_req_pulse", 32'(sdr_req), 32'h0);
    step();
    chk("lat_wait4", 32'(ioctl_wait), 32'h1);
    step();
    chk("lat_wait5", 32'(ioctl_wait), 32'h0);
    chk("lat_din", 32'(ioctl_din), 32'(exp_half(27'h300)));
    repeat (4) step();

    for (int i = 0; i < 10; i++) begin
      req_log.delete();
      do_rd(tbl[i].addr, d, s);
      repeat (8) step();
      chk($sformatf("vec%0d_din", i), 32'(d), 32'(tbl[i].din));
      chk($sformatf("vec%0d_stall", i), 32'(s), 32'(tbl[i].stall));
      chk($sformatf("vec%0d_nreq", i), 32'(req_log.size()), 32'(tbl[i].nreq));
      if (tbl[i].nreq > 0)
        chk($sformatf("vec%0d_reqaddr", i), (req_log.size() > 0) ? 32'(req_log[0]) : 32'hFFFFFFFF,
            32'(tbl[i].req));
    end

    // Read landing on an in-flight prefetch of the same word.
    do_rd(27'h12, d, s);
    repeat (4) step();
    req_log.delete();
    ioctl_addr = 27'h12;
    ioctl_rd = 1'b1;
    step();
    chk("pf_hit_wait", 32'(ioctl_wait), 32'h0);
    chk("pf_hit_din", 32'(ioctl_din), 32'(exp_half(27'h12)));
    ioctl_addr = 27'h14;
    step();
    ioctl_rd = 1'b0;
    chk("pf_rd_wait", 32'(ioctl_wait), 32'h1);
    for (int n = 0; n < 40 && ioctl_wait === 1'b1; n++) step();
    chk("pf_rd_din", 32'(ioctl_din), 32'(exp_half(27'h14)));
    repeat (6) step();
    chk("pf_rd_nreq", 32'(req_log.size()), 32'h1);

    // Read landing on a prefetch of a different word: fill, then a fresh demand fetch.
    do_rd(27'h22, d, s);
    repeat (4) step();
    req_log.delete();
    ioctl_addr = 27'h22;
    ioctl_rd = 1'b1;
    step();
    ioctl_addr = 27'h40;
    step();
    ioctl_rd = 1'b0;
    chk("pf_miss_wait", 32'(ioctl_wait), 32'h1);
    for (int n = 0; n < 40 && ioctl_wait === 1'b1; n++) step();
    chk("pf_miss_din", 32'(ioctl_din), 32'(exp_half(27'h40)));
    repeat (6) step();
    chk("pf_miss_nreq", 32'(req_log.size()), 32'h2);
    chk("pf_miss_addr", (req_log.size() > 1) ? 32'(req_log[1]) : 32'hFFFFFFFF, 32'(BASE + 27'h40));

    // Session dropped while the access is outstanding.
    lat = 6;
    req_log.delete();
    d0 = ioctl_din;
    ioctl_addr = 27'h500;
    ioctl_rd = 1'b1;
    step();
    ioctl_rd = 1'b0;
    step();
    step();
    ioctl_upload = 1'b0;
    step();
    chk("abort_wait", 32'(ioctl_wait), 32'h0);
    chk("abort_active", 32'(active), 32'h0);
    repeat (10) step();
    chk("abort_din", 32'(ioctl_din), 32'(d0));
    chk("abort_nreq", 32'(req_log.size()), 32'h1);
    lat = 2;
    ioctl_upload = 1'b1;
    repeat (2) step();
    do_rd(27'h500, d, s);
    chk("abort_refetch_stall", 32'(s), 32'h1);
    chk("abort_refetch_din", 32'(d), 32'(exp_half(27'h500)));

    // Reset while an access is outstanding; the late completion must be ignored.
    lat = 4;
    ioctl_addr = 27'h600;
    ioctl_rd = 1'b1;
    step();
    ioctl_rd = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    repeat (8) step();
    chk("rstmid_din", 32'(ioctl_din), 32'h0);
    chk("rstmid_wait", 32'(ioctl_wait), 32'h0);
    lat = 2;
    do_rd(27'h600, d, s);
    chk("rstmid_stall", 32'(s), 32'h1);
    chk("rstmid_rd_din", 32'(d), 32'(exp_half(27'h600)));

    // Wrong index: strobes are ignored entirely.
    ioctl_index = 8'd1;
    repeat (2) step();
    chk("widx_active", 32'(active), 32'h0);
    d0 = ioctl_din;
    req_log.delete();
    for (int i = 0; i < 4; i++) begin
      ioctl_addr = 27'(i * 4 + 2);
      ioctl_rd = 1'b1;
      step();
      ioctl_rd = 1'b0;
      chk("widx_wait", 32'(ioctl_wait), 32'h0);
      step();
    end
    repeat (4) step();
    chk("widx_nreq", 32'(req_log.size()), 32'h0);
    chk("widx_din", 32'(ioctl_din), 32'(d0));

    // Random reads with random SDRAM latency against the address model.
    ioctl_index = 8'd2;
    repeat (2) step();
    rand_lat = 1'b1;
    a = 27'h0;
    prev_w = 27'h7FFFFFF;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = a + 27'd2;
        6, 7: a = 27'($urandom_range(0, 511) * 2);
        8: a = a;
        default: a = 27'h7FFFFF0 + 27'($urandom_range(0, 7) * 2);
      endcase
      cur_w = {a[26:2], 2'b00};
      req_log.delete();
      do_rd(a, d, s);
      chk($sformatf("rnd%0d_din", i), 32'(d), 32'(exp_half(a)));
      ok = 1'b1;
      foreach (req_log[k]) begin
        base_w = req_log[k];
        if (base_w != BASE + cur_w && base_w != BASE + cur_w + 27'd4 &&
            base_w != BASE + prev_w + 27'd4)
          ok = 1'b0;
      end
      chk($sformatf("rnd%0d_reqaddr", i), 32'(ok), 32'h1);
      prev_w = cur_w;
      repeat ($urandom_range(0, 2)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
